// File: rtl/clk_div_gen_pkg.sv
// Shared definitions for the clock divider generator: FSM states and the
// smallest divide ratio a channel will accept.
package clk_div_gen_pkg;

  typedef enum logic [1:0] {
    ST_ALIGN   = 2'd0,
    ST_LOCKING = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: free-running counter, phase load on alignment,
// and registered square-wave / rising-edge strobe outputs.
module clk_div_chan
  import clk_div_gen_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             align_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             outclk_o,
  output logic             outclk_en_o
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;
  logic             outclkEn_q, outclkEn_d;
  logic [DIV_W:0]   highLen;

  // Widened by one bit so the rounding-up add cannot overflow at full-scale div.
  always_comb begin
    highLen    = ({1'b0, div_i} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    cnt_d      = cnt_q;
    outclk_d   = 1'b0;
    outclkEn_d = 1'b0;
    if (align_i) begin
      cnt_d = phase_i;
    end else begin
      cnt_d      = (cnt_q >= div_i - ONE) ? '0 : cnt_q + ONE;
      outclk_d   = ({1'b0, cnt_q} < highLen);
      outclkEn_d = (cnt_q == '0);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      outclk_q   <= 1'b0;
      outclkEn_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      outclk_q   <= outclk_d;
      outclkEn_q <= outclkEn_d;
    end
  end

  assign outclk_o    = outclk_q;
  assign outclk_en_o = outclkEn_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider with runtime div/phase reconfiguration; any
// accepted change realigns all channels and re-runs the lock interval.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter  int NUM_CLK     = 4,
  parameter  int DIV_W       = 16,
  parameter  int DEF_DIV     = 5,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_chan,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_phase,
  output logic [NUM_CLK-1:0] outclk,
  output logic [NUM_CLK-1:0] outclk_en,
  output logic               locked
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LC_W-1:0]  LOCK_LAST = LC_W'(LOCK_CYCLES - 1);
  localparam logic [LC_W-1:0]  LC_ONE    = LC_W'(1);
  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEF_DIV_C = (DEF_DIV < MIN_DIV) ? MIN_DIV_V : DIV_W'(DEF_DIV);

  state_e           state_q, state_d;
  logic [LC_W-1:0]  lockCnt_q, lockCnt_d;
  logic [DIV_W-1:0] div_q   [NUM_CLK];
  logic [DIV_W-1:0] phase_q [NUM_CLK];
  logic [DIV_W-1:0] cfgDivClamped, cfgPhaseClamped;
  logic             accept, chanOk, xferOk, align;

  assign cfg_ready = (state_q != ST_ALIGN);
  assign locked    = (state_q == ST_RUN);
  assign align     = (state_q == ST_ALIGN);
  assign accept    = cfg_valid && cfg_ready;
  assign chanOk    = (int'(cfg_chan) < NUM_CLK);
  assign xferOk    = accept && chanOk;

  // A phase that would never be reached by the counter is treated as zero.
  always_comb begin
    cfgDivClamped   = (cfg_div < MIN_DIV_V) ? MIN_DIV_V : cfg_div;
    cfgPhaseClamped = (cfg_phase < cfgDivClamped) ? cfg_phase : '0;
  end

  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    case (state_q)
      ST_ALIGN: begin
        state_d   = ST_LOCKING;
        lockCnt_d = '0;
      end
      ST_LOCKING: begin
        if (lockCnt_q == LOCK_LAST) state_d = ST_RUN;
        else                        lockCnt_d = lockCnt_q + LC_ONE;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_ALIGN;
    endcase
    if (xferOk) state_d = ST_ALIGN;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ALIGN;
      lockCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
    end
  end

  // Out-of-range channel writes are accepted but land nowhere.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        div_q[i]   <= DEF_DIV_C;
        phase_q[i] <= '0;
      end
    end else if (xferOk) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        if (cfg_chan == CH_W'(i)) begin
          div_q[i]   <= cfgDivClamped;
          phase_q[i] <= cfgPhaseClamped;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CLK; g++) begin : gChan
    clk_div_chan #(
      .DIV_W(DIV_W)
    ) uChan (
      .refclk     (refclk),
      .rst        (rst),
      .align_i    (align),
      .div_i      (div_q[g]),
      .phase_i    (phase_q[g]),
      .outclk_o   (outclk[g]),
      .outclk_en_o(outclk_en[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: a cycle model feeds an expected-output
// queue, plus directed timing checks on strobes, periods and lock delay.
module tb_clk_div_gen;

  localparam int NCH  = 4;
  localparam int LOCK = 16;

  typedef struct packed {
    logic           locked;
    logic           ready;
    logic [NCH-1:0] clk;
    logic [NCH-1:0] en;
  } exp_t;

  logic           refclk = 1'b0;
  logic           rst    = 1'b0;
  logic           cfgValid;
  logic           cfgReady;
  logic [1:0]     cfgChan;
  logic [15:0]    cfgDiv, cfgPhase;
  logic [NCH-1:0] outclk, outclkEn;
  logic           locked;

  logic           oddValid, oddReady, oddLocked;
  logic [1:0]     oddChan;
  logic [15:0]    oddDiv, oddPhase;
  logic [2:0]     oddClk, oddEn;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cyc = 0;

  exp_t expQ[$];
  int   mDiv[NCH];
  int   mPhase[NCH];
  int   mT;
  bit   mAlign;

  clk_div_gen dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfgValid),
    .cfg_ready(cfgReady),
    .cfg_chan (cfgChan),
    .cfg_div  (cfgDiv),
    .cfg_phase(cfgPhase),
    .outclk   (outclk),
    .outclk_en(outclkEn),
    .locked   (locked)
  );

  // Three channels so that an out-of-range index is representable on cfg_chan.
  clk_div_gen #(.NUM_CLK(3)) dutOdd (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(oddValid),
    .cfg_ready(oddReady),
    .cfg_chan (oddChan),
    .cfg_div  (oddDiv),
    .cfg_phase(oddPhase),
    .outclk   (oddClk),
    .outclk_en(oddEn),
    .locked   (oddLocked)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mDiv[i]   = 5;
      mPhase[i] = 0;
    end
    mAlign = 1'b1;
    mT     = 0;
    expQ.delete();
  endtask

  // Channel position is phase plus cycles elapsed since alignment, modulo div.
  task automatic modelStep();
    exp_t e;
    int   c, d, p;
    bit   acc;
    if (rst) begin
      modelReset();
      return;
    end
    e   = '0;
    acc = cfgValid && !mAlign && (int'(cfgChan) < NCH);
    if (mAlign) begin
      mT     = 0;
      mAlign = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        c        = (mPhase[i] + mT) % mDiv[i];
        e.clk[i] = (c < (mDiv[i] + 1) / 2);
        e.en[i]  = (c == 0);
      end
      mT++;
      if (acc) begin
        d = (int'(cfgDiv) < 2) ? 2 : int'(cfgDiv);
        p = (int'(cfgPhase) < d) ? int'(cfgPhase) : 0;
        mDiv[cfgChan]   = d;
        mPhase[cfgChan] = p;
        mAlign = 1'b1;
      end
    end
    e.ready  = !mAlign;
    e.locked = !mAlign && (mT >= LOCK);
    expQ.push_back(e);
  endtask

  always @(posedge refclk or posedge rst) modelStep();

  task automatic scoreCheck();
    exp_t e;
    if (rst || expQ.size() == 0) return;
    e = expQ.pop_front();
    checkOutput("sbLocked", {31'b0, locked}, {31'b0, e.locked});
    checkOutput("sbReady", {31'b0, cfgReady}, {31'b0, e.ready});
    checkOutput("sbOutclk", {28'b0, outclk}, {28'b0, e.clk});
    checkOutput("sbStrobe", {28'b0, outclkEn}, {28'b0, e.en});
  endtask

  always @(negedge refclk) scoreCheck();

  task automatic applyStimulus(input int ch, input int div, input int ph, output int tE);
    int n = 0;
    while (!cfgReady && n < 40) begin
      @(posedge refclk); #1;
      n++;
    end
    checkOutput("readyWait", {31'b0, cfgReady}, 1);
    cfgValid = 1'b1;
    cfgChan  = 2'(ch);
    cfgDiv   = 16'(div);
    cfgPhase = 16'(ph);
    @(posedge refclk); #1;
    cfgValid = 1'b0;
    tE = cyc;
  endtask

  task automatic measurePeriod(input int ch, output int per, output int high);
    int n = 0;
    per  = -1;
    high = -1;
    @(negedge refclk);
    while (!outclkEn[ch] && n < 40) begin
      @(negedge refclk);
      n++;
    end
    if (!outclkEn[ch]) return;
    per  = 1;
    high = outclk[ch] ? 1 : 0;
    @(negedge refclk);
    while (!outclkEn[ch] && per < 40) begin
      per++;
      high += outclk[ch] ? 1 : 0;
      @(negedge refclk);
    end
  endtask

  task automatic checkPeriod(input int ch, input int per, input int high);
    int p, h;
    measurePeriod(ch, p, h);
    checkOutput($sformatf("period%0d", ch), p, per);
    checkOutput($sformatf("high%0d", ch), h, high);
  endtask

  // Called right after a transfer edge; skips the alignment edge first.
  task automatic strobeGap(input int a, input int b, output int gap);
    int fa = -1, fb = -1;
    @(posedge refclk);
    for (int n = 0; n < 40; n++) begin
      @(negedge refclk);
      if (outclkEn[a] && fa < 0) fa = cyc;
      if (outclkEn[b] && fb < 0) fb = cyc;
      if (fa >= 0 && fb >= 0) break;
    end
    gap = (fa < 0 || fb < 0) ? 999 : fb - fa;
  endtask

  task automatic waitLocked(input int tRef, output int dt);
    int n = 0;
    @(negedge refclk);
    while (!locked && n < 60) begin
      @(negedge refclk);
      n++;
    end
    dt = locked ? cyc - tRef : -1;
  endtask

  task automatic releaseAndCheckDefaults();
    int tR, fEn = -1, fLock = -1;
    rst = 1'b0;
    tR  = cyc;
    for (int n = 0; n < 30; n++) begin
      @(negedge refclk);
      if (outclkEn[0] && fEn < 0) fEn = cyc;
      if (locked && fLock < 0)    fLock = cyc;
    end
    checkOutput("firstStrobe", fEn - tR, 2);
    checkOutput("lockDelay", fLock - tR, 1 + LOCK);
    for (int ch = 0; ch < NCH; ch++) checkPeriod(ch, 5, 3);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Outclk"}, {28'b0, outclk}, 0);
    checkOutput({tag, "Strobe"}, {28'b0, outclkEn}, 0);
    checkOutput({tag, "Locked"}, {31'b0, locked}, 0);
    checkOutput({tag, "Ready"}, {31'b0, cfgReady}, 0);
  endtask

  initial begin
    int tE, tA, gap, dt, nEn, nHigh;
    cfgValid = 1'b0; cfgChan = '0; cfgDiv = '0; cfgPhase = '0;
    oddValid = 1'b0; oddChan = '0; oddDiv = '0; oddPhase = '0;

    #2 rst = 1'b1;
    repeat (2) @(posedge refclk);
    #1;
    checkAllZero("reset");
    releaseAndCheckDefaults();

    $display("[TB] reconfigure channel 1 in RUN");
    applyStimulus(1, 8, 3, tE);
    checkOutput("lockedDrop", {31'b0, locked}, 0);
    strobeGap(0, 1, gap);
    checkOutput("ch1Offset", gap, 5);
    waitLocked(tE, dt);
    checkOutput("relockDelay", dt, 1 + LOCK);
    checkPeriod(1, 8, 4);
    checkPeriod(0, 5, 3);

    $display("[TB] divide clamping and phase range");
    applyStimulus(2, 0, 0, tE);
    checkPeriod(2, 2, 1);
    applyStimulus(2, 1, 0, tE);
    checkPeriod(2, 2, 1);
    applyStimulus(3, 4, 9, tE);
    strobeGap(0, 3, gap);
    checkOutput("ch3PhaseZero", gap, 0);
    checkPeriod(3, 4, 2);
    waitLocked(tE, dt);
    checkOutput("lockAfterClamp", dt, 1 + LOCK);

    $display("[TB] transfer during LOCKING");
    applyStimulus(0, 5, 0, tA);
    repeat (5) @(posedge refclk);
    #1;
    applyStimulus(0, 5, 0, tE);
    waitLocked(tE, dt);
    checkOutput("lockFromSecond", dt, 1 + LOCK);
    checkOutput("lockFromFirst", cyc - tA, 1 + LOCK + 6);

    $display("[TB] reset in RUN after reconfiguration");
    @(posedge refclk); #1;
    rst = 1'b1;
    #1;
    checkAllZero("midReset");
    @(posedge refclk); #1;
    releaseAndCheckDefaults();

    $display("[TB] out-of-range channel on 3-channel instance");
    checkOutput("oddLockedBefore", {31'b0, oddLocked}, 1);
    @(posedge refclk); #1;
    oddValid = 1'b1; oddChan = 2'd3; oddDiv = 16'd8; oddPhase = 16'd0;
    nEn = 0; nHigh = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge refclk);
      checkOutput("oddLocked", {31'b0, oddLocked}, 1);
      checkOutput("oddReady", {31'b0, oddReady}, 1);
      nEn   += $countones(oddEn);
      nHigh += $countones(oddClk);
    end
    oddValid = 1'b0;
    checkOutput("oddStrobes", nEn, 6);
    checkOutput("oddHighCycles", nHigh, 18);

    repeat (3) @(posedge refclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
